// File: rtl/feature_ram_sched_if.sv
// Request/read-beat bundle between the aggregation control FSM (master)
// and the feature RAM read scheduler (slave).
interface feature_ram_sched_if #(
    parameter int FEAT_W = 12,
    parameter int ADDR_W = 9,
    parameter int N_BANK = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [FEAT_W-1:0] req_start;
    logic [FEAT_W-1:0] req_stop;
    logic              rd_valid;
    logic              rd_ready;
    logic [N_BANK-1:0] rd_bank_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_start, req_stop, rd_ready,
        input  req_ready, rd_valid, rd_bank_en, rd_addr, rd_last, done, err
    );

    modport slave (
        input  req_valid, req_start, req_stop, rd_ready,
        output req_ready, rd_valid, rd_bank_en, rd_addr, rd_last, done, err
    );
endinterface

// File: rtl/feature_ram_sched.sv
// Banked feature RAM read scheduler: walks an inclusive feature-ID range, one beat per transfer.
// Define FRS_ABORT_EN to add an abort input that cancels a running range without a done pulse.
module feature_ram_sched #(
    parameter int FEAT_W = 12,
    parameter int ADDR_W = 9,
    parameter int N_BANK = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef FRS_ABORT_EN
    input  logic abort,
`endif
    feature_ram_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [FEAT_W-1:0] stop_q, stop_d;
    logic [FEAT_W-1:0] cur_q, cur_d;
    logic [FEAT_W-1:0] nxt;
    logic              rd_valid_q, rd_valid_d;
    logic [N_BANK-1:0] bank_en_q, bank_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;
    logic              abort_hit;

`ifdef FRS_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [N_BANK-1:0] bank_onehot(input logic [FEAT_W-1:0] id);
        return N_BANK'(1) << id[FEAT_W-1:ADDR_W];
    endfunction

    assign xfer = rd_valid_q & bus.rd_ready;
    assign nxt  = cur_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        stop_d     = stop_q;
        cur_d      = cur_q;
        rd_valid_d = rd_valid_q;
        bank_en_d  = bank_en_q;
        addr_d     = addr_q;
        last_d     = last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    stop_d = bus.req_stop;
                    if (bus.req_start > bus.req_stop) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        cur_d      = bus.req_start;
                        rd_valid_d = 1'b1;
                        bank_en_d  = bank_onehot(bus.req_start);
                        addr_d     = bus.req_start[ADDR_W-1:0];
                        last_d     = (bus.req_start == bus.req_stop);
                    end
                end
            end
            RUN: begin
                // Last is decided on cur before incrementing, so stop=max never wraps.
                if (xfer && last_q) begin
                    state_d    = DONE;
                    rd_valid_d = 1'b0;
                    bank_en_d  = '0;
                    addr_d     = '0;
                    last_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (xfer) begin
                    cur_d     = nxt;
                    bank_en_d = bank_onehot(nxt);
                    addr_d    = nxt[ADDR_W-1:0];
                    last_d    = (nxt == stop_q);
                end
                // A beat taken in the abort cycle still counts; nothing follows it.
                if (abort_hit) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b0;
                    bank_en_d  = '0;
                    addr_d     = '0;
                    last_d     = 1'b0;
                    done_d     = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stop_q     <= '0;
            cur_q      <= '0;
            rd_valid_q <= 1'b0;
            bank_en_q  <= '0;
            addr_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            cur_q      <= cur_d;
            rd_valid_q <= rd_valid_d;
            bank_en_q  <= bank_en_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_bank_en = bank_en_q;
    assign bus.rd_addr    = addr_q;
    assign bus.rd_last    = last_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_feature_ram_sched.sv
// Bench for feature_ram_sched: directed range table, random ranges against a feature-ID queue model,
// plus reset-mid-run and (with FRS_ABORT_EN) abort sequences.
module tb_feature_ram_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef FRS_ABORT_EN
    logic abort = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    feature_ram_sched_if bus ();

    feature_ram_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FRS_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    typedef struct {
        int start;
        int stop;
        bit rnd;
        int stall_at;
        int stall_len;
        int exp_beats;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_req(input int s, input int e, input bit rnd, input int stall_at,
                          input int stall_len, input int exp_beats);
        int q[$];
        int k;
        int stalled;
        int budget;
        int id;
        bit rdy;
        for (int i = s; i <= e; i++) q.push_back(i);
        chk("req_ready idle", 32'(bus.req_ready), 1);
        bus.req_start = 12'(s);
        bus.req_stop  = 12'(e);
        bus.req_valid = 1'b1;
        bus.rd_ready  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (s > e) begin
            chk("err pulse", 32'(bus.err), 1);
            chk("err rd_valid", 32'(bus.rd_valid), 0);
            chk("err req_ready", 32'(bus.req_ready), 1);
            @(negedge clk);
            chk("err width", 32'(bus.err), 0);
            chk("err idle rd_valid", 32'(bus.rd_valid), 0);
            return;
        end
        chk("first beat latency", 32'(bus.rd_valid), 1);
        k = 0;
        stalled = 0;
        budget = q.size() * 8 + 20;
        while (q.size() > 0 && budget > 0) begin
            budget--;
            id = q[0];
            chk("rd_valid", 32'(bus.rd_valid), 1);
            chk("early done", 32'(bus.done), 0);
            chk("req_ready busy", 32'(bus.req_ready), 0);
            chk("bank_en", 32'(bus.rd_bank_en), 32'(1) << (id / 512));
            chk("addr", 32'(bus.rd_addr), 32'(id % 512));
            chk("last", 32'(bus.rd_last), 32'(id == e));
            if (rnd) rdy = ($urandom_range(0, 3) != 0);
            else if (k == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else rdy = 1'b1;
            bus.rd_ready = rdy;
            // Requests offered while busy must be ignored.
            bus.req_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_start = 12'($urandom_range(0, 4095));
            bus.req_stop  = 12'($urandom_range(0, 4095));
            if (rdy) begin
                void'(q.pop_front());
                k++;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rd_ready  = 1'b0;
        chk("beat count", 32'(k), 32'(exp_beats));
        chk("done pulse", 32'(bus.done), 1);
        chk("done rd_valid", 32'(bus.rd_valid), 0);
        chk("done bank_en", 32'(bus.rd_bank_en), 0);
        chk("done req_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        chk("done width", 32'(bus.done), 0);
        chk("back idle", 32'(bus.req_ready), 1);
        chk("idle rd_valid", 32'(bus.rd_valid), 0);
    endtask

    initial begin
        int s;
        int e;
        vecs[0] = '{0,    3,    1'b0, -1, 0, 4};
        vecs[1] = '{510,  513,  1'b0, -1, 0, 4};
        vecs[2] = '{100,  102,  1'b0,  1, 3, 3};
        vecs[3] = '{5,    2,    1'b0, -1, 0, 0};
        vecs[4] = '{4095, 4095, 1'b0, -1, 0, 1};
        vecs[5] = '{511,  512,  1'b0, -1, 0, 2};
        vecs[6] = '{4000, 4095, 1'b1, -1, 0, 96};
        vecs[7] = '{7,    7,    1'b0, -1, 0, 1};

        bus.req_valid = 1'b0;
        bus.req_start = '0;
        bus.req_stop  = '0;
        bus.rd_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rd_valid", 32'(bus.rd_valid), 0);
        chk("reset bank_en", 32'(bus.rd_bank_en), 0);
        chk("reset addr", 32'(bus.rd_addr), 0);
        chk("reset last", 32'(bus.rd_last), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset err", 32'(bus.err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready after reset", 32'(bus.req_ready), 1);

        for (int i = 0; i < 8; i++)
            do_req(vecs[i].start, vecs[i].stop, vecs[i].rnd, vecs[i].stall_at,
                   vecs[i].stall_len, vecs[i].exp_beats);

        for (int i = 0; i < 25; i++) begin
            s = int'($urandom_range(0, 4095));
            if (s > 0 && $urandom_range(0, 5) == 0) e = s - int'($urandom_range(1, s));
            else e = (s + int'($urandom_range(0, 40)) > 4095) ? 4095 : s + int'($urandom_range(0, 40));
            do_req(s, e, 1'b1, -1, 0, (e >= s) ? e - s + 1 : 0);
        end

        // Reset in the middle of a long range.
        bus.req_start = 12'd0;
        bus.req_stop  = 12'd1000;
        bus.req_valid = 1'b1;
        bus.rd_ready  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid-run addr", 32'(bus.rd_addr), 20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst rd_valid", 32'(bus.rd_valid), 0);
        chk("rst bank_en", 32'(bus.rd_bank_en), 0);
        chk("rst addr", 32'(bus.rd_addr), 0);
        chk("rst last", 32'(bus.rd_last), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst req_ready", 32'(bus.req_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst done", 32'(bus.done), 0);
        chk("post-rst rd_valid", 32'(bus.rd_valid), 0);
        bus.rd_ready = 1'b0;

`ifdef FRS_ABORT_EN
        bus.req_start = 12'd0;
        bus.req_stop  = 12'd50;
        bus.req_valid = 1'b1;
        bus.rd_ready  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-abort addr", 32'(bus.rd_addr), 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort rd_valid", 32'(bus.rd_valid), 0);
        chk("abort done", 32'(bus.done), 0);
        chk("abort req_ready", 32'(bus.req_ready), 1);
        @(negedge clk);
        chk("abort no done", 32'(bus.done), 0);
        chk("abort stays off", 32'(bus.rd_valid), 0);
        bus.rd_ready = 1'b0;
        do_req(3, 4, 1'b0, -1, 0, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
